dmem_responder: RTL and testbench

- Synchronous data-memory responder for the pipelined RV32I core; the slave end of the load/store interface.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs byte, half-word or word access with RV32I sign/zero extension, then returns read data and an error flag over a second valid/ready handshake.
- Sits between the MEM stage and the word-organised data RAM.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_responder.sv | 181 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, widths and helpers for the data-memory responder.
// Build option: DMEM_ALIGN_CHECK_EN turns misaligned accesses into errors.
package dmem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BE_W   = XLEN / 8;

  typedef enum logic [CTRL_W-1:0] {
    B  = 3'b000,
    H  = 3'b001,
    W  = 3'b010,
    BU = 3'b100,
    HU = 3'b101
  } dmem_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Unsigned loads have no store counterpart.
  function automatic logic ctrl_legal(logic [CTRL_W-1:0] ctrl, logic we);
    logic ok;
    case (ctrl)
      B, H, W: ok = 1'b1;
      BU, HU:  ok = ~we;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and replicated store data, plus
// sign/zero-extended load data selected from the raw RAM word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [XLEN-1:0]   wword_o,
  output logic [XLEN-1:0]   ldata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte   = rdata_i[{addr_lo_i, 3'b000} +: 8];
    rhalf   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o    = '0;
    wword_o = '0;
    ldata_o = '0;
    case (ctrl_i)
      B: begin
        be_o    = BE_W'(1) << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{rbyte[7]}}, rbyte};
      end
      BU: begin
        be_o    = BE_W'(1) << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        ldata_o = {24'b0, rbyte};
      end
      H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        ldata_o = {{16{rhalf[15]}}, rhalf};
      end
      HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        ldata_o = {16'b0, rhalf};
      end
      W: begin
        be_o    = '1;
        wword_o = wdata_i;
        ldata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states, RV32I
// byte/half/word access, valid/ready response. Option: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_ctrl,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned IdxW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned LimW  = XLEN + 1;
  localparam logic [LimW-1:0]  AddrLimit = LimW'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] WaitInit  = CNT_W'(WAIT_STATES);

  localparam logic [1:0] StIdle = IDLE;
  localparam logic [1:0] StWait = WAIT;
  localparam logic [1:0] StResp = RESP;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              we_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   addr_q, wdata_q;

  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  logic              req_fire, enter_resp, misalign, acc_err;
  logic              acc_we;
  logic [CTRL_W-1:0] acc_ctrl;
  logic [XLEN-1:0]   acc_addr, acc_wdata, eff_addr;
  logic [IdxW-1:0]   widx;
  logic [BE_W-1:0]   be;
  logic [XLEN-1:0]   wword, ldata, rword;

  assign req_fire = req_valid & req_ready;

  // With no wait states the RAM is accessed on the accept edge itself,
  // before the captured copy exists, so the live request is used then.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_ctrl  = req_ctrl;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_ctrl  = ctrl_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    eff_addr = acc_addr;
    misalign = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    case (acc_ctrl)
      H, HU:   misalign = acc_addr[0];
      W:       misalign = |acc_addr[1:0];
      default: ;
    endcase
`else
    case (acc_ctrl)
      H, HU:   eff_addr[0]   = 1'b0;
      W:       eff_addr[1:0] = 2'b00;
      default: ;
    endcase
`endif
    // No wrap-around: anything past the last word faults.
    acc_err = misalign | ~ctrl_legal(acc_ctrl, acc_we) | ({1'b0, eff_addr} >= AddrLimit);
  end

  assign widx  = eff_addr[IdxW+1:2];
  assign rword = mem[widx];

  dmem_lane_align u_lane_align (
    .ctrl_i    (acc_ctrl),
    .addr_lo_i (eff_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rdata_i   (rword),
    .be_o      (be),
    .wword_o   (wword),
    .ldata_o   (ldata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = WaitInit;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err | acc_we) ? '0 : ldata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      we_q    <= req_we;
      ctrl_q  <= req_ctrl;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // RAM is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table through a scoreboard,
// plus latency, backpressure and reset-during-wait sequences.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned WaitStates = 1;
  localparam int unsigned Wait3      = 3;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif
  localparam logic [2:0] CB = 3'b000, CH = 3'b001, CW = 3'b010, CBU = 3'b100, CHU = 3'b101;

  typedef struct {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk;
  logic        reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        r3_reset, r3_req_valid, r3_req_ready, r3_req_we, r3_rsp_valid, r3_rsp_ready;
  logic        r3_rsp_err;
  logic [2:0]  r3_req_ctrl;
  logic [31:0] r3_req_addr, r3_req_wdata, r3_rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WaitStates)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(Wait3)) u_dut3 (
    .clk       (clk),
    .reset     (r3_reset),
    .req_valid (r3_req_valid),
    .req_ready (r3_req_ready),
    .req_we    (r3_req_we),
    .req_ctrl  (r3_req_ctrl),
    .req_addr  (r3_req_addr),
    .req_wdata (r3_req_wdata),
    .rsp_valid (r3_rsp_valid),
    .rsp_ready (r3_rsp_ready),
    .rsp_rdata (r3_rsp_rdata),
    .rsp_err   (r3_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: a response is compared on the cycle its handshake completes.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h with no request pending", rsp_rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("rsp%0d_rdata", e.id), rsp_rdata, e.rdata);
        check($sformatf("rsp%0d_err", e.id), {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic push_exp(input int id, input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.id    = id;
    sb_q.push_back(e);
  endtask

  task automatic send(input int id, input logic we, input logic [2:0] ctrl,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    push_exp(id, exp_rd, exp_err);
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept%0d: req_ready stayed 0 for %0d cycles, required 1", id, n);
      void'(sb_q.pop_back());
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || !req_ready) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || !req_ready) begin
      errors++;
      $display("FAIL %s: %0d responses outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic send3(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                       output int lat);
    int n = 0;
    r3_req_valid = 1'b1;
    r3_req_we    = we;
    r3_req_ctrl  = ctrl;
    r3_req_addr  = addr;
    r3_req_wdata = wdata;
    @(negedge clk);
    while (!r3_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    r3_req_valid = 1'b0;
    lat = 0;
    while (!r3_rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = r3_rsp_rdata;
    er = r3_rsp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          n;
    logic [31:0] rd;
    logic        er;

    reset = 1'b0;  req_valid = 1'b0;  req_we = 1'b0;  req_ctrl = CW;
    req_addr = '0; req_wdata = '0;    rsp_ready = 1'b1;
    r3_reset = 1'b0; r3_req_valid = 1'b0; r3_req_we = 1'b0; r3_req_ctrl = CW;
    r3_req_addr = '0; r3_req_wdata = '0; r3_rsp_ready = 1'b1;

    // Error responses always carry zero data.
    vecs.push_back('{1'b1, CW,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, CW,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, CB,  32'h13,   32'h0,        32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, CBU, 32'h13,   32'h0,        32'h000000DE, 1'b0});
    vecs.push_back('{1'b0, CH,  32'h10,   32'h0,        32'hFFFFBEEF, 1'b0});
    vecs.push_back('{1'b0, CHU, 32'h12,   32'h0,        32'h0000DEAD, 1'b0});
    vecs.push_back('{1'b1, CB,  32'h11,   32'h00000055, 32'h0,        1'b0});
    vecs.push_back('{1'b0, CW,  32'h10,   32'h0,        32'hDEAD55EF, 1'b0});
    vecs.push_back('{1'b1, CW,  32'h14,   32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b1, CH,  32'h16,   32'h0000A5C3, 32'h0,        1'b0});
    vecs.push_back('{1'b0, CW,  32'h14,   32'h0,        32'hA5C33344, 1'b0});
    vecs.push_back('{1'b0, CB,  32'h16,   32'h0,        32'hFFFFFFC3, 1'b0});
    vecs.push_back('{1'b0, CBU, 32'h17,   32'h0,        32'h000000A5, 1'b0});
    vecs.push_back('{1'b0, CH,  32'h14,   32'h0,        32'h00003344, 1'b0});
    vecs.push_back('{1'b1, CW,  32'h0,    32'h0BADF00D, 32'h0,        1'b0});
    vecs.push_back('{1'b1, CW,  32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, CW,  32'h1000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, CW,  32'h0,    32'h0,        32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b1, CBU, 32'h0,    32'h000000FF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b011, 32'h0, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b111, 32'h4, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, CW,  32'h0,    32'h0,        32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b0, CW,  32'h12,   32'h0, AlignChk ? 32'h0 : 32'hDEAD55EF, AlignChk});
    vecs.push_back('{1'b0, CH,  32'h11,   32'h0, AlignChk ? 32'h0 : 32'h000055EF, AlignChk});
    vecs.push_back('{1'b0, CHU, 32'h13,   32'h0, AlignChk ? 32'h0 : 32'h0000DEAD, AlignChk});
    vecs.push_back('{1'b1, CW,  32'h2,    32'h77777777, 32'h0, AlignChk});
    vecs.push_back('{1'b0, CW,  32'h0,    32'h0, AlignChk ? 32'h0BADF00D : 32'h77777777, 1'b0});
    vecs.push_back('{1'b0, CW,  32'h1002, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, CW,  32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0});
    vecs.push_back('{1'b0, CW,  32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'b0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err",   {31'b0, rsp_err},   32'h0);
    reset    = 1'b1;
    r3_reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      send(i, vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
    end
    drain("table_drain");

    // Accept edge to first rsp_valid: one edge per wait state.
    send(100, 1'b0, CW, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, WaitStates);
    drain("latency_drain");

    // Backpressure with a second request held behind the stalled response.
    rsp_ready = 1'b0;
    send(101, 1'b0, CW, 32'h14, 32'h0, 32'hA5C33344, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    push_exp(102, 32'hFFFFFFDE, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_ctrl  = CB;
    req_addr  = 32'h13;
    req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'hA5C33344);
      check("bp_rsp_err",   {31'b0, rsp_err},   32'h0);
      check("bp_req_ready", {31'b0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_accept_after_rsp", sb_q.size(), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain("bp_drain");

    // Reset while a store waits on the 3-wait-state instance.
    send3(1'b1, CW, 32'h20, 32'hAAAA5555, rd, er, lat);
    check("u3_latency", lat, Wait3);
    check("u3_store_err", {31'b0, er}, 32'h0);
    r3_req_valid = 1'b1;
    r3_req_we    = 1'b1;
    r3_req_ctrl  = CW;
    r3_req_addr  = 32'h20;
    r3_req_wdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk);
    #1;
    r3_req_valid = 1'b0;
    @(posedge clk);
    #1;
    r3_reset = 1'b0;
    @(posedge clk);
    #1;
    check("u3_rst_rsp_valid", {31'b0, r3_rsp_valid}, 32'h0);
    check("u3_rst_req_ready", {31'b0, r3_req_ready}, 32'h1);
    r3_reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("u3_no_late_rsp", {31'b0, r3_rsp_valid}, 32'h0);
    send3(1'b0, CW, 32'h20, 32'h0, rd, er, lat);
    check("u3_load_after_rst", rd, 32'hAAAA5555);
    check("u3_load_err", {31'b0, er}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
